pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FLUSH_CYCLES, default 1: bubble cycles after a redirect, legal range 1..3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  hazard unit freeze request; fetch PC held.
REQ-006 ex_valid  input  1  EX stage holds a live instruction.
REQ-007 ex_cf  input  1  EX instruction is branch/jump; branch unit result meaningful.
REQ-008 ex_res_pc  input  32  next PC computed by branch unit for the EX instruction.
REQ-009 ex_pred_pc  input  32  PC fetched after the EX instruction (carried down pipeline).
REQ-010 if_hint  input  1  fetch-stage predecode: B-type with negative immediate (used only under STATIC_PREDICT_EN).
REQ-011 if_hint_tgt  input  32  predecoded target for if_hint.
REQ-012 if_pc  output  32  current fetch address.
REQ-013 if_valid  output  1  if_pc is a real fetch; 0 during bubbles.
REQ-014 flush  output  1  kill IF/ID and ID/EX contents this cycle.
REQ-015 misalign_err  output  1  sticky: redirect target not word-aligned.
REQ-016 state_o  output  2  current FSM state, for debug/bench.

Function
REQ-017 FSM states: BOOT=2'd0, RUN=2'd1, FLUSH=2'd2, HALT=2'd3.
REQ-018 BOOT: if_pc=RESET_PC, if_valid=0; unconditionally to RUN next cycle.
REQ-019 RUN: if_valid=1; mispredict = ex_valid & ex_cf & (ex_res_pc != ex_pred_pc).
REQ-020 RUN, mispredict, ex_res_pc[1:0]==0: flush=1 same cycle (combinational), if_pc <= ex_res_pc, counter <= FLUSH_CYCLES-1, -> FLUSH.
REQ-021 RUN, mispredict, ex_res_pc[1:0]!=0: flush=1, misalign_err <= 1, if_pc held, -> HALT.
REQ-022 Mispredict has priority over stall; stall never delays a redirect.
REQ-023 RUN, no mispredict, stall=1: if_pc held, flush=0.
REQ-024 RUN, no mispredict, stall=0: if_pc <= next sequential fetch (REQ-031/032).
REQ-025 PC increment: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, no error.
REQ-026 FLUSH: if_valid=0, flush=0, if_pc held; counter decrements; exit to RUN when counter==0 and stall=0; stall=1 holds FLUSH with counter frozen at 0.
REQ-027 FLUSH ignores ex_* inputs (pipeline already killed).
REQ-028 HALT: if_valid=0, flush=0, if_pc frozen; exit only by rst.
REQ-029 ex_cf=1 with ex_valid=0 is ignored.
REQ-030 Redirect-to-fetch latency: mispredict in cycle N -> if_pc=ex_res_pc in N+1, if_valid=1 in N+1+FLUSH_CYCLES.

Configuration
REQ-031 Macro STATIC_PREDICT_EN defined: RUN sequential step selects if_hint_tgt when if_hint=1 (backward-taken), else if_pc+4; a misaligned if_hint_tgt is not predicted (falls back to +4).
REQ-032 STATIC_PREDICT_EN undefined: step is always if_pc+4; if_hint/if_hint_tgt unconnected internally, no logic generated.

Reset
REQ-033 rst=1 at any clock edge, any state including mid-FLUSH/HALT: state<=BOOT, if_pc<=RESET_PC, counter<=0, misalign_err<=0.
REQ-034 While rst=1: if_valid=0, flush=0; reset overrides all inputs.

Structure
REQ-035 Shared package rv32_pkg holds FSM state encodings, XLEN=32, PC step constant 4, default reset vector.
REQ-036 One sub-module pc_next: combinational next-PC mux (sequential/predicted/redirect) with the 32-bit adder; FSM and registers stay in pc_ctrl.

Verification
REQ-037 rst 1 cycle, then run with stall=0 -> BOOT one cycle, if_pc 0x0,0x4,0x8 with if_valid=1 from cycle 2.
REQ-038 In RUN, ex_valid=ex_cf=1, ex_res_pc=0x100, ex_pred_pc=0x14, stall=1 -> flush=1 that cycle, if_pc=0x100 next, if_valid=0 for FLUSH_CYCLES then 1.
REQ-039 ex_res_pc=0x102 mispredict -> misalign_err=1, state HALT, if_pc frozen; rst -> BOOT, misalign_err=0.
REQ-040 if_pc=0xFFFF_FFFC, stall=0, no mispredict -> if_pc=0x0000_0000 next, no error.
REQ-041 STATIC_PREDICT_EN defined, if_hint=1, if_hint_tgt=0x40 -> if_pc=0x40 next; ex later reports ex_res_pc=ex_pred_pc=0x40 -> no flush. Undefined build, same stimulus -> if_pc+4.
REQ-042 rst asserted during FLUSH with FLUSH_CYCLES=3 -> next cycle BOOT, if_pc=RESET_PC, counter=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared fetch-control types and constants
package rv32_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;
   localparam logic [XLEN-1:0] RESET_VEC = 32'h0000_0000;
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } pc_state_e;
endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: pipeline-to-fetch-control signal bundle; slave is pc_ctrl, master drives it
interface pc_ctrl_if;
   import rv32_pkg::*;
   logic            stall;
   logic            ex_valid;
   logic            ex_cf;
   logic [XLEN-1:0] ex_res_pc;
   logic [XLEN-1:0] ex_pred_pc;
   logic            if_hint;
   logic [XLEN-1:0] if_hint_tgt;
   logic [XLEN-1:0] if_pc;
   logic            if_valid;
   logic            flush;
   logic            misalign_err;
   logic [1:0]      state_o;
   modport slave (
      input  stall, ex_valid, ex_cf, ex_res_pc, ex_pred_pc, if_hint, if_hint_tgt,
      output if_pc, if_valid, flush, misalign_err, state_o
   );
   modport master (
      output stall, ex_valid, ex_cf, ex_res_pc, ex_pred_pc, if_hint, if_hint_tgt,
      input  if_pc, if_valid, flush, misalign_err, state_o
   );
endinterface

// File: rtl/pc_next.sv
// pc_next: next fetch address mux (redirect / predicted / sequential); STATIC_PREDICT_EN adds backward-branch hint
module pc_next
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] res_pc,
`ifdef STATIC_PREDICT_EN
  input  logic            hint,
  input  logic [XLEN-1:0] hint_tgt,
`endif
  output logic [XLEN-1:0] next_pc
);
  logic [XLEN-1:0] seq_pc;
  always_comb begin
`ifdef STATIC_PREDICT_EN
    seq_pc = hint && hint_tgt[1:0] == 2'b00 ? hint_tgt : pc + PC_STEP;
`else
    seq_pc = pc + PC_STEP;
`endif
    next_pc = redirect ? res_pc : seq_pc;
  end
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch PC controller with redirect flush and misalignment halt; macro STATIC_PREDICT_EN enables hint prediction
module pc_ctrl
   import rv32_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC     = RESET_VEC,
   parameter int              FLUSH_CYCLES = 1
) (
   input logic     clk,
   input logic     rst,
   pc_ctrl_if.slave bus
);
   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, pc_cand;
   logic [1:0]      cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            mispredict, redirect;
   assign mispredict = bus.ex_valid & bus.ex_cf & (bus.ex_res_pc != bus.ex_pred_pc);
   assign redirect   = (state_q == RUN) & mispredict;
   pc_next u_next (
      .pc       (pc_q),
      .redirect (mispredict),
      .res_pc   (bus.ex_res_pc),
`ifdef STATIC_PREDICT_EN
      .hint     (bus.if_hint),
      .hint_tgt (bus.if_hint_tgt),
`endif
      .next_pc  (pc_cand)
   );
   // next-state, PC, flush counter and sticky error; mispredict outranks stall
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         BOOT:  state_d = RUN;
         RUN:
            if (mispredict) begin
               if (bus.ex_res_pc[1:0] == 2'b00) begin
                  pc_d    = pc_cand;
                  cnt_d   = 2'(FLUSH_CYCLES - 1);
                  state_d = FLUSH;
               end else begin
                  err_d   = 1'b1;
                  state_d = HALT;
               end
            end else if (!bus.stall) pc_d = pc_cand;
         FLUSH:
            if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
            else if (!bus.stall) state_d = RUN;
         HALT:  state_d = HALT;
      endcase
   end
   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         cnt_q   <= 2'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end
   assign bus.if_pc        = pc_q;
   assign bus.if_valid     = (state_q == RUN) & ~rst;
   assign bus.flush        = redirect & ~rst;
   assign bus.misalign_err = err_q;
   assign bus.state_o      = state_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: scoreboard bench for pc_ctrl against a cycle-level behavioural model
module tb_pc_ctrl;
   localparam int FC = 3;
   typedef struct {
      logic [31:0] pc;
      logic        v;
      logic        f;
      logic        e;
      logic [1:0]  st;
      bit          known;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   pc_ctrl_if bus ();
   pc_ctrl #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(FC)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          m_mode = 0;
   int          m_wait = 0;
   logic [31:0] m_pc = 32'd0;
   logic        m_err = 1'b0;
   bit          m_known = 1'b0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask
   // monitor: every cycle the DUT presents outputs; pop the expectation and compare
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("if_valid", 32'(bus.if_valid), 32'(e.v));
         chk("flush", 32'(bus.flush), 32'(e.f));
         if (e.known) begin
            chk("if_pc", bus.if_pc, e.pc);
            chk("misalign_err", 32'(bus.misalign_err), 32'(e.e));
            chk("state", 32'(bus.state_o), 32'(e.st));
         end
      end
   end
   task automatic cyc(input logic r, input logic s, input logic ev, input logic cf,
                      input logic [31:0] res, input logic [31:0] pred,
                      input logic h, input logic [31:0] tgt);
      exp_t e;
      logic mis;
      @(posedge clk);
      #1;
      rst = r; bus.stall = s; bus.ex_valid = ev; bus.ex_cf = cf;
      bus.ex_res_pc = res; bus.ex_pred_pc = pred; bus.if_hint = h; bus.if_hint_tgt = tgt;
      mis = ev && cf && (res != pred);
      e.pc = m_pc; e.e = m_err; e.st = 2'(m_mode); e.known = m_known;
      e.v = !r && m_mode == 1;
      e.f = !r && m_mode == 1 && mis;
      q.push_back(e);
      if (r) begin
         m_mode = 0; m_pc = 32'd0; m_err = 1'b0; m_wait = 0; m_known = 1'b1;
      end else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
         if (mis) begin
            if (res % 4 == 0) begin
               m_pc = res; m_wait = FC; m_mode = 2;
            end else begin
               m_err = 1'b1; m_mode = 3;
            end
         end else if (!s) begin
`ifdef STATIC_PREDICT_EN
            m_pc = (h && tgt % 4 == 0) ? tgt : m_pc + 32'd4;
`else
            m_pc = m_pc + 32'd4;
`endif
         end
      end else if (m_mode == 2) begin
         if (m_wait > 1) m_wait--;
         else if (!s) m_mode = 1;
      end
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'd0, 32'd0, 0, 32'd0);
   endtask
   // stimulus: directed scenarios then randomized traffic
   initial begin
      int halt_cnt;
      logic [31:0] pred, res, tgt;
      int r;
      bus.stall = 0; bus.ex_valid = 0; bus.ex_cf = 0; bus.ex_res_pc = 0;
      bus.ex_pred_pc = 0; bus.if_hint = 0; bus.if_hint_tgt = 0;
      cyc(1, 0, 0, 0, 32'd0, 32'd0, 0, 32'd0);
      idle(4);
      cyc(0, 1, 1, 1, 32'h100, 32'h14, 0, 32'd0);
      idle(FC + 3);
      cyc(0, 0, 1, 1, 32'hFFFF_FFF8, 32'h0, 0, 32'd0);
      idle(FC + 4);
      cyc(0, 0, 0, 0, 32'd0, 32'd0, 1, 32'h40);
      cyc(0, 0, 1, 1, 32'h40, 32'h40, 0, 32'd0);
      idle(2);
      cyc(0, 1, 1, 1, 32'h200, 32'h20, 0, 32'd0);
      cyc(0, 1, 1, 1, 32'h300, 32'h30, 0, 32'd0);
      idle(FC + 2);
      cyc(0, 0, 1, 1, 32'h102, 32'h10, 0, 32'd0);
      idle(3);
      cyc(1, 0, 0, 0, 32'd0, 32'd0, 0, 32'd0);
      idle(3);
      cyc(0, 0, 1, 1, 32'h500, 32'h50, 0, 32'd0);
      cyc(0, 0, 0, 0, 32'd0, 32'd0, 0, 32'd0);
      cyc(1, 0, 0, 0, 32'd0, 32'd0, 0, 32'd0);
      idle(3);
      halt_cnt = 0;
      for (int i = 0; i < 2000; i++) begin
         r = $urandom_range(0, 99);
         pred = $urandom & 32'hFFFF_FFFC;
         res = (r < 65) ? pred : (r < 97) ? ($urandom & 32'hFFFF_FFFC) : (($urandom & 32'hFFFF_FFFC) | 32'd1);
         tgt = ($urandom_range(0, 3) == 0) ? ($urandom | 32'd2) : ($urandom & 32'hFFFF_FFFC);
         halt_cnt = (m_mode == 3) ? halt_cnt + 1 : 0;
         cyc((halt_cnt > 3) || ($urandom_range(0, 79) == 0), $urandom_range(0, 3) == 0,
             1'($urandom), 1'($urandom), res, pred, $urandom_range(0, 3) == 0, tgt);
      end
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
